decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
- Parametrised next-generation decode stage for the 16-bit pipelined CPU, sitting between fetch and execute.
- Owns the register file, operand forwarding (E, W bypass, optional M), load-use hazard detection and branch resolution in D.
- Drives a registered D/E pipeline register with a valid/stall handshake.
- Instruction layout, MSB first: opcode | src1 | src2 | dest.

Parameters:
- DATA_W, 16, register and operand width
- RADDR_W, 4, register address width; register file depth is 2**RADDR_W
- OPC_W, 4, opcode width; INST_W = OPC_W + 3*RADDR_W (derived, not overridable)
- PC_W, 12, program counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- inst_d  in  INST_W  instruction in D
- valid_d  in  1  inst_d is a real instruction
- pc_d  in  PC_W  PC of inst_d
- branch_d  in  1  inst_d is a branch-if-equal
- imm_sel_d  in  1  src2 operand is the zero-extended src2 field
- wr_en_w  in  1  writeback enable
- wr_addr_w  in  RADDR_W  writeback address
- wr_data_w  in  DATA_W  writeback data
- fwd_en_e  in  1  E-stage instruction writes a register
- fwd_addr_e  in  RADDR_W  E-stage destination
- fwd_data_e  in  DATA_W  E-stage ALU result
- load_e  in  1  E-stage instruction is a load (data not yet available)
- stall_e  in  1  execute cannot accept a new instruction
- stall_d  out  1  D must hold; fetch must not advance
- branch_taken  out  1  redirect fetch this cycle
- pc_branch  out  PC_W  branch target
- valid_e  out  1  D/E register holds a real instruction
- opcode_e  out  OPC_W  registered opcode
- dest_e  out  RADDR_W  registered destination
- src1_e  out  DATA_W  registered operand 1
- src2_e  out  DATA_W  registered operand 2 (immediate already applied)

Behaviour:
- Reset (reset==0 at rising edge):
  - all register-file entries become 0
  - valid_e, opcode_e, dest_e, src1_e and src2_e become 0
  - Reset wins over every other event, including a mid-stall or a same-cycle write.
- Register file: DATA_W x 2**RADDR_W.
  - Write on rising edge when wr_en_w=1.
  - Two combinational read ports.
- Operand select per source, highest priority first:
  1. E forward: fwd_en_e=1 and fwd_addr_e==src address
  2. M forward (only when the optional feature is compiled in)
  3. W bypass: wr_en_w=1 and wr_addr_w==src address, giving same-cycle write-through
  4. register-file read
- imm_sel_d=1:
  - src2 operand = zero-extended src2 field.
  - The src2 field is not treated as a register read for hazard purposes.
- Load-use hazard: valid_d=1, load_e=1, fwd_en_e=1 and fwd_addr_e matches a used source field.
  - stall_d=1.
  - D/E loads a bubble: valid_e=0, other D/E fields hold their previous values.
- stall_e=1:
  - stall_d=1.
  - The D/E register holds all fields unchanged.
  - stall_e overrides bubble insertion.
- stall_d = hazard OR stall_e, combinational.
- Otherwise D/E captures valid_d, opcode, dest and the selected operands.
  - Latency: 1 cycle from D to E outputs.
- Branch:
  - branch_taken=1 iff valid_d=1, branch_d=1, stall_d=0 and operand1==operand2, using the forwarded operand values.
  - pc_branch = pc_d + sign-extended dest field, modulo 2**PC_W (wraps).
  - pc_branch is driven every cycle; it is only meaningful while branch_taken=1.
  - Combinational, 0-cycle latency; fetch squashes its own slot.
  - The branch still enters D/E with valid_e=valid_d.
- valid_d=0: no hazard, no branch; a bubble propagates.

Optional Feature:
- Macro DECODE_FWD_MEM_EN.
- Defined:
  - adds ports fwd_en_m (in, 1), fwd_addr_m (in, RADDR_W) and fwd_data_m (in, DATA_W).
  - M forwarding is priority 2.
  - A load in M forwards its data; only a load in E stalls.
- Undefined:
  - the ports are absent.
  - Operands come from E forward, W bypass or the register file only.

Decomposition:
- Package decode_pkg holds:
  - default width constants
  - INST_W derivation
  - field-slice offset constants
  - a typedef for the D/E bundle (valid, opcode, dest, src1, src2)
- One sub-module, decode_regfile: storage, reset clear, two read ports and the W bypass.
- Forwarding, hazard detection, branch logic and the D/E register stay in decode_stage_p.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read r3 -> src1_e=0 and valid_e=0; after a write of r3=0x1234 and a read of r3, src1_e=0x1234 one cycle later.
- Write-through: wr_en_w=1, wr_addr_w=5, wr_data_w=0xBEEF, with inst_d reading r5 in the same cycle -> src1_e=0xBEEF next cycle.
- Forward priority: E forwards r2=0x0011 while W writes r2=0x0022 -> src1_e=0x0011.
- Load-use: load_e=1, fwd_addr_e=4, inst_d src2=r4 -> stall_d=1 and valid_e=0 next cycle; load_e=0 on the following cycle -> instruction issues with the W-bypassed value.
- Branch: r1=r2=7, branch_d=1, pc_d=0x0FE, dest field=0x3 -> branch_taken=1, pc_branch=0x101. Dest field=0xF -> pc_branch=0x0FD. pc_d=0xFFF with dest field=0x1 -> pc_branch=0x000.
- stall_e held for 3 cycles with a new inst_d -> D/E outputs unchanged, stall_d=1, branch_taken=0 even when operands are equal.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants and types for the decode stage of the
//                16-bit pipelined CPU. Holds the default widths, the derived
//                instruction width, the field-slice offsets of the
//                instruction word (opcode | src1 | src2 | dest, MSB first),
//                the D/E pipeline bundle and the operand-source encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // --------------------------------------------------------------------------
  // Default configuration
  // --------------------------------------------------------------------------
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 4;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_PC_W    = 12;

  // Instruction width: one opcode plus three register-address fields.
  function automatic int inst_w(input int opc_w, input int raddr_w);
    return opc_w + 3 * raddr_w;
  endfunction

  localparam int DEF_INST_W = inst_w(DEF_OPC_W, DEF_RADDR_W);

  // --------------------------------------------------------------------------
  // Field slicing. Every field sits at a multiple of RADDR_W from bit 0;
  // the index below is that multiple.
  // --------------------------------------------------------------------------
  localparam int DEST_FIELD = 0;
  localparam int SRC2_FIELD = 1;
  localparam int SRC1_FIELD = 2;
  localparam int OPC_FIELD  = 3;

  function automatic int field_lsb(input int field_idx, input int raddr_w);
    return field_idx * raddr_w;
  endfunction

  localparam int DEF_DEST_LSB = field_lsb(DEST_FIELD, DEF_RADDR_W);
  localparam int DEF_SRC2_LSB = field_lsb(SRC2_FIELD, DEF_RADDR_W);
  localparam int DEF_SRC1_LSB = field_lsb(SRC1_FIELD, DEF_RADDR_W);
  localparam int DEF_OPC_LSB  = field_lsb(OPC_FIELD,  DEF_RADDR_W);

  // --------------------------------------------------------------------------
  // D/E pipeline bundle at the default widths. The stage itself rebuilds the
  // same layout from its own parameters so it stays correct when overridden.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic                   valid;
    logic [DEF_OPC_W-1:0]   opcode;
    logic [DEF_RADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0]  src1;
    logic [DEF_DATA_W-1:0]  src2;
  } de_bundle_t;

  // Where an operand comes from after forwarding resolution.
  typedef enum logic [1:0] {
    OPSRC_RF  = 2'd0,  // register file (includes W write-through)
    OPSRC_E   = 2'd1,  // E-stage forward
    OPSRC_M   = 2'd2,  // M-stage forward (optional build)
    OPSRC_IMM = 2'd3   // zero-extended src2 field
  } opsrc_e;

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : decode_regfile
//  Description : DATA_W x 2**RADDR_W register file with two combinational
//                read ports. A write in the same cycle as a read of the same
//                address is passed straight through to the read port (W
//                bypass). Synchronous active-low reset clears every entry
//                and wins over a same-cycle write.
//  Ports       : clk, reset        - clock, sync active-low reset
//                wr_en/addr/data   - write port (W stage)
//                rd_addr1/2        - read addresses
//                rd_data1/2        - read data, bypass applied
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [RADDR_W-1:0] rd_addr1,
  input  logic [RADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]  rd_data1,
  output logic [DATA_W-1:0]  rd_data2
);

  localparam int DEPTH = 2 ** RADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Write-through keeps a W-stage result visible to D in the same cycle.
  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    rd_data2 = mem_q[rd_addr2];
    if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
    if (wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_p
//  Description : Decode stage of the 16-bit pipelined CPU. Reads operands
//                from the register file, resolves forwarding from E (and
//                optionally M) plus the W write-through, detects load-use
//                hazards, resolves branch-if-equal in D and drives the
//                registered D/E pipeline register.
//  Build macro : DECODE_FWD_MEM_EN - adds the M-stage forwarding ports
//                (fwd_en_m, fwd_addr_m, fwd_data_m) at priority 2.
//  Ports       : clk, reset            - clock, sync active-low reset
//                inst_d/valid_d/pc_d   - instruction in D
//                branch_d, imm_sel_d   - branch / immediate src2 flags
//                wr_*_w                - writeback port
//                fwd_*_e, load_e       - E-stage forward and load flag
//                stall_e               - execute back-pressure
//                stall_d               - D hold request to fetch
//                branch_taken/pc_branch- fetch redirect
//                valid_e..src2_e       - D/E pipeline register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_p
  import decode_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int RADDR_W = DEF_RADDR_W,
  parameter  int OPC_W   = DEF_OPC_W,
  parameter  int PC_W    = DEF_PC_W,
  localparam int INST_W  = inst_w(OPC_W, RADDR_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INST_W-1:0]  inst_d,
  input  logic               valid_d,
  input  logic [PC_W-1:0]    pc_d,
  input  logic               branch_d,
  input  logic               imm_sel_d,
  input  logic               wr_en_w,
  input  logic [RADDR_W-1:0] wr_addr_w,
  input  logic [DATA_W-1:0]  wr_data_w,
  input  logic               fwd_en_e,
  input  logic [RADDR_W-1:0] fwd_addr_e,
  input  logic [DATA_W-1:0]  fwd_data_e,
  input  logic               load_e,
  input  logic               stall_e,
`ifdef DECODE_FWD_MEM_EN
  input  logic               fwd_en_m,
  input  logic [RADDR_W-1:0] fwd_addr_m,
  input  logic [DATA_W-1:0]  fwd_data_m,
`endif
  output logic               stall_d,
  output logic               branch_taken,
  output logic [PC_W-1:0]    pc_branch,
  output logic               valid_e,
  output logic [OPC_W-1:0]   opcode_e,
  output logic [RADDR_W-1:0] dest_e,
  output logic [DATA_W-1:0]  src1_e,
  output logic [DATA_W-1:0]  src2_e
);

  localparam int DEST_LSB = field_lsb(DEST_FIELD, RADDR_W);
  localparam int SRC2_LSB = field_lsb(SRC2_FIELD, RADDR_W);
  localparam int SRC1_LSB = field_lsb(SRC1_FIELD, RADDR_W);
  localparam int OPC_LSB  = field_lsb(OPC_FIELD,  RADDR_W);

  // Same layout as decode_pkg::de_bundle_t, sized from this instance.
  typedef struct packed {
    logic               valid;
    logic [OPC_W-1:0]   opcode;
    logic [RADDR_W-1:0] dest;
    logic [DATA_W-1:0]  src1;
    logic [DATA_W-1:0]  src2;
  } de_t;

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [OPC_W-1:0]   opc;
  logic [RADDR_W-1:0] src1_addr;
  logic [RADDR_W-1:0] src2_addr;
  logic [RADDR_W-1:0] dest_addr;

  assign opc       = inst_d[OPC_LSB  +: OPC_W];
  assign src1_addr = inst_d[SRC1_LSB +: RADDR_W];
  assign src2_addr = inst_d[SRC2_LSB +: RADDR_W];
  assign dest_addr = inst_d[DEST_LSB +: RADDR_W];

  // --------------------------------------------------------------------------
  // Register file (W bypass lives inside it)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;

  decode_regfile #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en_w),
    .wr_addr  (wr_addr_w),
    .wr_data  (wr_data_w),
    .rd_addr1 (src1_addr),
    .rd_addr2 (src2_addr),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2)
  );

  // --------------------------------------------------------------------------
  // Operand source selection: E forward, then M forward, then register file.
  // --------------------------------------------------------------------------
  opsrc_e op1_sel;
  opsrc_e op2_sel;

  always_comb begin
    op1_sel = OPSRC_RF;
    if (fwd_en_e && (fwd_addr_e == src1_addr)) begin
      op1_sel = OPSRC_E;
    end
`ifdef DECODE_FWD_MEM_EN
    else if (fwd_en_m && (fwd_addr_m == src1_addr)) begin
      op1_sel = OPSRC_M;
    end
`endif
  end

  always_comb begin
    op2_sel = OPSRC_RF;
    if (imm_sel_d) begin
      op2_sel = OPSRC_IMM;
    end else if (fwd_en_e && (fwd_addr_e == src2_addr)) begin
      op2_sel = OPSRC_E;
    end
`ifdef DECODE_FWD_MEM_EN
    else if (fwd_en_m && (fwd_addr_m == src2_addr)) begin
      op2_sel = OPSRC_M;
    end
`endif
  end

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  always_comb begin
    op1 = rf_data1;
    case (op1_sel)
      OPSRC_E: op1 = fwd_data_e;
`ifdef DECODE_FWD_MEM_EN
      OPSRC_M: op1 = fwd_data_m;
`endif
      default: op1 = rf_data1;
    endcase
  end

  always_comb begin
    op2 = rf_data2;
    case (op2_sel)
      OPSRC_E:   op2 = fwd_data_e;
`ifdef DECODE_FWD_MEM_EN
      OPSRC_M:   op2 = fwd_data_m;
`endif
      OPSRC_IMM: op2 = DATA_W'(src2_addr);
      default:   op2 = rf_data2;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load-use hazard. Only a load still in E stalls: its data is not ready.
  // An immediate src2 field is not a register read, so it cannot collide.
  // --------------------------------------------------------------------------
  logic src1_hit;
  logic src2_hit;
  logic hazard;

  assign src1_hit = (fwd_addr_e == src1_addr);
  assign src2_hit = !imm_sel_d && (fwd_addr_e == src2_addr);
  assign hazard   = valid_d && load_e && fwd_en_e && (src1_hit || src2_hit);
  assign stall_d  = hazard || stall_e;

  // --------------------------------------------------------------------------
  // Branch resolution in D. The dest field doubles as a signed PC offset.
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] br_offset;

  assign br_offset    = PC_W'($signed(dest_addr));
  assign pc_branch    = pc_d + br_offset;
  assign branch_taken = valid_d && branch_d && !stall_d && (op1 == op2);

  // --------------------------------------------------------------------------
  // D/E pipeline register. stall_e freezes everything and takes precedence
  // over bubble insertion; a hazard only clears valid.
  // --------------------------------------------------------------------------
  de_t de_q;
  de_t de_d;

  always_comb begin
    de_d = de_q;
    if (stall_e) begin
      de_d = de_q;
    end else if (hazard) begin
      de_d.valid = 1'b0;
    end else begin
      de_d.valid  = valid_d;
      de_d.opcode = opc;
      de_d.dest   = dest_addr;
      de_d.src1   = op1;
      de_d.src2   = op2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign valid_e  = de_q.valid;
  assign opcode_e = de_q.opcode;
  assign dest_e   = de_q.dest;
  assign src1_e   = de_q.src1;
  assign src2_e   = de_q.src2;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_p
//  Description : Directed self-checking bench for decode_stage_p at the
//                default configuration (16-bit data, 4-bit register
//                addresses, 4-bit opcode, 12-bit PC).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst_d;
  logic        valid_d;
  logic [11:0] pc_d;
  logic        branch_d;
  logic        imm_sel_d;
  logic        wr_en_w;
  logic [3:0]  wr_addr_w;
  logic [15:0] wr_data_w;
  logic        fwd_en_e;
  logic [3:0]  fwd_addr_e;
  logic [15:0] fwd_data_e;
  logic        load_e;
  logic        stall_e;
  logic        stall_d;
  logic        branch_taken;
  logic [11:0] pc_branch;
  logic        valid_e;
  logic [3:0]  opcode_e;
  logic [3:0]  dest_e;
  logic [15:0] src1_e;
  logic [15:0] src2_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk          (clk),
    .reset        (reset),
    .inst_d       (inst_d),
    .valid_d      (valid_d),
    .pc_d         (pc_d),
    .branch_d     (branch_d),
    .imm_sel_d    (imm_sel_d),
    .wr_en_w      (wr_en_w),
    .wr_addr_w    (wr_addr_w),
    .wr_data_w    (wr_data_w),
    .fwd_en_e     (fwd_en_e),
    .fwd_addr_e   (fwd_addr_e),
    .fwd_data_e   (fwd_data_e),
    .load_e       (load_e),
    .stall_e      (stall_e),
    .stall_d      (stall_d),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch),
    .valid_e      (valid_e),
    .opcode_e     (opcode_e),
    .dest_e       (dest_e),
    .src1_e       (src1_e),
    .src2_e       (src2_e)
  );

  function automatic logic [15:0] mk(input logic [3:0] o, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] d);
    return {o, s1, s2, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_d = '0; valid_d = 1'b0; pc_d = '0; branch_d = 1'b0; imm_sel_d = 1'b0;
    wr_en_w = 1'b0; wr_addr_w = '0; wr_data_w = '0;
    fwd_en_e = 1'b0; fwd_addr_e = '0; fwd_data_e = '0;
    load_e = 1'b0; stall_e = 1'b0;
  endtask

  task automatic test_reset();
    // A write attempted during reset must be lost.
    reset = 1'b0; valid_d = 1'b1; inst_d = mk(4'h1, 4'h3, 4'h3, 4'h3);
    wr_en_w = 1'b1; wr_addr_w = 4'h3; wr_data_w = 16'h5555;
    tick(); tick();
    n_checks++; if (valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_valid_e: got %b expected 0", valid_e); end
    n_checks++; if (src1_e !== 16'h0) begin n_fail++; $display("FAIL reset_src1_e: got %h expected 0000", src1_e); end
    n_checks++; if (opcode_e !== 4'h0 || dest_e !== 4'h0 || src2_e !== 16'h0) begin
      n_fail++; $display("FAIL reset_fields: got opc %h dest %h src2 %h expected all 0", opcode_e, dest_e, src2_e); end
    reset = 1'b1; wr_en_w = 1'b0; inst_d = mk(4'h1, 4'h3, 4'h0, 4'h3);
    tick();
    n_checks++; if (src1_e !== 16'h0) begin n_fail++; $display("FAIL reset_rf_clear: got %h expected 0000", src1_e); end
    n_checks++; if (valid_e !== 1'b1) begin n_fail++; $display("FAIL reset_first_issue: got %b expected 1", valid_e); end
    valid_d = 1'b0; wr_en_w = 1'b1; wr_addr_w = 4'h3; wr_data_w = 16'h1234;
    tick();
    wr_en_w = 1'b0; valid_d = 1'b1; inst_d = mk(4'h2, 4'h3, 4'h0, 4'h0);
    tick();
    n_checks++; if (src1_e !== 16'h1234) begin n_fail++; $display("FAIL reset_wr_rd: got %h expected 1234", src1_e); end
  endtask

  task automatic test_writethrough();
    idle();
    wr_en_w = 1'b1; wr_addr_w = 4'h5; wr_data_w = 16'hBEEF;
    valid_d = 1'b1; inst_d = mk(4'h4, 4'h5, 4'h5, 4'h1);
    tick();
    n_checks++; if (src1_e !== 16'hBEEF) begin n_fail++; $display("FAIL wt_src1: got %h expected beef", src1_e); end
    n_checks++; if (src2_e !== 16'hBEEF) begin n_fail++; $display("FAIL wt_src2: got %h expected beef", src2_e); end
    n_checks++; if (opcode_e !== 4'h4 || dest_e !== 4'h1) begin
      n_fail++; $display("FAIL wt_fields: got opc %h dest %h expected 4 1", opcode_e, dest_e); end
    idle();
    valid_d = 1'b1; inst_d = mk(4'h4, 4'h0, 4'h5, 4'h1);
    tick();
    n_checks++; if (src2_e !== 16'hBEEF || src1_e !== 16'h0) begin
      n_fail++; $display("FAIL wt_stored: got src1 %h src2 %h expected 0000 beef", src1_e, src2_e); end
  endtask

  task automatic test_forward();
    idle();
    fwd_en_e = 1'b1; fwd_addr_e = 4'h2; fwd_data_e = 16'h0011;
    wr_en_w = 1'b1; wr_addr_w = 4'h2; wr_data_w = 16'h0022;
    valid_d = 1'b1; inst_d = mk(4'h6, 4'h2, 4'h2, 4'h3);
    tick();
    n_checks++; if (src1_e !== 16'h0011) begin n_fail++; $display("FAIL fwd_prio_src1: got %h expected 0011", src1_e); end
    n_checks++; if (src2_e !== 16'h0011) begin n_fail++; $display("FAIL fwd_prio_src2: got %h expected 0011", src2_e); end
    idle();
    valid_d = 1'b1; inst_d = mk(4'h6, 4'h2, 4'h0, 4'h3);
    tick();
    n_checks++; if (src1_e !== 16'h0022) begin n_fail++; $display("FAIL fwd_w_stored: got %h expected 0022", src1_e); end
    // Immediate beats any forward matching the src2 field.
    idle();
    fwd_en_e = 1'b1; fwd_addr_e = 4'hA; fwd_data_e = 16'h9999;
    imm_sel_d = 1'b1; valid_d = 1'b1; inst_d = mk(4'h7, 4'h0, 4'hA, 4'h0);
    tick();
    n_checks++; if (src2_e !== 16'h000A) begin n_fail++; $display("FAIL imm_src2: got %h expected 000a", src2_e); end
  endtask

  task automatic test_load_use();
    idle();
    valid_d = 1'b1; inst_d = mk(4'h9, 4'h5, 4'h0, 4'h2);
    tick();
    inst_d = mk(4'h3, 4'h0, 4'h4, 4'h6);
    load_e = 1'b1; fwd_en_e = 1'b1; fwd_addr_e = 4'h4; fwd_data_e = 16'hDEAD;
    #1;
    n_checks++; if (stall_d !== 1'b1) begin n_fail++; $display("FAIL lu_stall_d: got %b expected 1", stall_d); end
    tick();
    n_checks++; if (valid_e !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b expected 0", valid_e); end
    n_checks++; if (opcode_e !== 4'h9 || dest_e !== 4'h2 || src1_e !== 16'hBEEF) begin
      n_fail++; $display("FAIL lu_hold: got opc %h dest %h src1 %h expected 9 2 beef", opcode_e, dest_e, src1_e); end
    load_e = 1'b0; fwd_en_e = 1'b0;
    wr_en_w = 1'b1; wr_addr_w = 4'h4; wr_data_w = 16'h4444;
    #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b expected 0", stall_d); end
    tick();
    n_checks++; if (valid_e !== 1'b1 || opcode_e !== 4'h3 || dest_e !== 4'h6 || src2_e !== 16'h4444) begin
      n_fail++; $display("FAIL lu_issue: got v %b opc %h dest %h src2 %h expected 1 3 6 4444",
                         valid_e, opcode_e, dest_e, src2_e); end
    // Immediate src2 field is not a register read.
    idle();
    load_e = 1'b1; fwd_en_e = 1'b1; fwd_addr_e = 4'h4;
    imm_sel_d = 1'b1; valid_d = 1'b1; inst_d = mk(4'h3, 4'h0, 4'h4, 4'h6);
    #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_imm_no_stall: got %b expected 0", stall_d); end
    // A bubble in D raises no hazard even when src1 matches.
    imm_sel_d = 1'b0; valid_d = 1'b0; inst_d = mk(4'h3, 4'h4, 4'h0, 4'h6);
    #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_invalid_no_stall: got %b expected 0", stall_d); end
    tick();
  endtask

  task automatic test_branch();
    idle();
    wr_en_w = 1'b1; wr_addr_w = 4'h1; wr_data_w = 16'h0007;
    tick();
    idle();
    wr_en_w = 1'b1; wr_addr_w = 4'h2; wr_data_w = 16'h0007;
    valid_d = 1'b1; branch_d = 1'b1; pc_d = 12'h0FE; inst_d = mk(4'h8, 4'h1, 4'h2, 4'h3);
    #1;
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL br_taken: got %b expected 1", branch_taken); end
    n_checks++; if (pc_branch !== 12'h101) begin n_fail++; $display("FAIL br_pc_fwd: got %h expected 101", pc_branch); end
    inst_d = mk(4'h8, 4'h1, 4'h2, 4'hF);
    #1;
    n_checks++; if (pc_branch !== 12'h0FD) begin n_fail++; $display("FAIL br_pc_back: got %h expected 0fd", pc_branch); end
    pc_d = 12'hFFF; inst_d = mk(4'h8, 4'h1, 4'h2, 4'h1);
    #1;
    n_checks++; if (pc_branch !== 12'h000) begin n_fail++; $display("FAIL br_pc_wrap: got %h expected 000", pc_branch); end
    inst_d = mk(4'h8, 4'h1, 4'h3, 4'h1);
    #1;
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL br_not_equal: got %b expected 0", branch_taken); end
    inst_d = mk(4'h8, 4'h1, 4'h2, 4'h3); valid_d = 1'b0;
    #1;
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL br_invalid: got %b expected 0", branch_taken); end
    valid_d = 1'b1; load_e = 1'b1; fwd_en_e = 1'b1; fwd_addr_e = 4'h1; fwd_data_e = 16'h0007;
    #1;
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL br_hazard: got %b expected 0", branch_taken); end
    load_e = 1'b0; fwd_en_e = 1'b0; pc_d = 12'h0FE;
    tick();
    n_checks++; if (valid_e !== 1'b1 || opcode_e !== 4'h8 || dest_e !== 4'h3) begin
      n_fail++; $display("FAIL br_enters_de: got v %b opc %h dest %h expected 1 8 3", valid_e, opcode_e, dest_e); end
  endtask

  task automatic test_stall_e();
    idle();
    valid_d = 1'b1; inst_d = mk(4'h5, 4'h1, 4'h2, 4'h7);
    tick();
    n_checks++; if (src1_e !== 16'h0007 || src2_e !== 16'h0007 || opcode_e !== 4'h5) begin
      n_fail++; $display("FAIL se_setup: got src1 %h src2 %h opc %h expected 0007 0007 5", src1_e, src2_e, opcode_e); end
    stall_e = 1'b1; branch_d = 1'b1; inst_d = mk(4'hC, 4'h3, 4'h3, 4'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stall_d !== 1'b1) begin n_fail++; $display("FAIL se_stall_d[%0d]: got %b expected 1", i, stall_d); end
      n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL se_no_branch[%0d]: got %b expected 0", i, branch_taken); end
      tick();
      n_checks++; if (valid_e !== 1'b1 || opcode_e !== 4'h5 || dest_e !== 4'h7 ||
                      src1_e !== 16'h0007 || src2_e !== 16'h0007) begin
        n_fail++; $display("FAIL se_hold[%0d]: got v %b opc %h dest %h src1 %h src2 %h expected 1 5 7 0007 0007",
                           i, valid_e, opcode_e, dest_e, src1_e, src2_e); end
    end
    // stall_e wins over bubble insertion.
    load_e = 1'b1; fwd_en_e = 1'b1; fwd_addr_e = 4'h3;
    tick();
    n_checks++; if (valid_e !== 1'b1) begin n_fail++; $display("FAIL se_over_bubble: got %b expected 1", valid_e); end
    idle();
    valid_d = 1'b1; inst_d = mk(4'hC, 4'h3, 4'h3, 4'h1);
    #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL se_release: got %b expected 0", stall_d); end
    tick();
    n_checks++; if (opcode_e !== 4'hC || src1_e !== 16'h1234 || dest_e !== 4'h1) begin
      n_fail++; $display("FAIL se_issue: got opc %h src1 %h dest %h expected c 1234 1", opcode_e, src1_e, dest_e); end
  endtask

  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_writethrough();
    test_forward();
    test_load_use();
    test_branch();
    test_stall_e();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
